// File: rtl/digit_pkg.sv
// Shared definitions for the digit-count scheduler: FSM encoding, divisor and default sizes.
package digit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned DIV_CONST = 10;

    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_W    = 32;
    localparam int unsigned DEF_CW   = 8;

    function automatic int unsigned digit_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_count_engine.sv
// Iterative decimal digit counter: one divide-by-10 per step, cnt tracks completed steps.
module digit_count_engine
    import digit_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [W-1:0]  operand_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [W-1:0]  q_q, q_d, q_div;
    logic [CW-1:0] cnt_q, cnt_d;

    assign q_div  = q_q / W'(DIV_CONST);
    assign last_o = (q_div == '0);
    // Count including the step taken this cycle, saturating.
    assign cnt_o  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (load_i) begin
            q_d   = operand_i;
            cnt_d = '0;
        end else if (step_i) begin
            q_d   = q_div;
            cnt_d = cnt_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_count_scheduler.sv
// Round-robin arbiter sharing one digit-count engine between NREQ requesters.
module digit_count_scheduler
    import digit_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned W    = DEF_W,
    parameter int unsigned CW   = DEF_CW,
    parameter int unsigned IDW  = digit_clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] num_i,
    output logic [NREQ-1:0]   ack_o,
    output logic              res_valid_o,
    output logic [CW-1:0]     res_count_o,
    output logic [IDW-1:0]    res_id_o,
    output logic              busy_o
);

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   res_count_q, res_count_d;
    logic [IDW-1:0]  res_id_q, res_id_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx, cand;
    logic            load, step, last;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    opnd [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_opnd
        assign opnd[g] = num_i[g*W +: W];
    end

    // First pending requester strictly after the last served one, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!grant_found && req_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        ack_d       = '0;
        valid_d     = 1'b0;
        res_count_d = res_count_q;
        res_id_d    = res_id_q;
        load        = 1'b0;
        step        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    load    = 1'b1;
                    id_d    = grant_idx;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d     = ST_DONE;
                    valid_d     = 1'b1;
                    ack_d       = NREQ'(1) << id_q;
                    res_count_d = cnt;
                    res_id_d    = id_q;
                end
            end
            ST_DONE: begin
                ptr_d   = id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            ack_q       <= '0;
            valid_q     <= 1'b0;
            res_count_q <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            ack_q       <= ack_d;
            valid_q     <= valid_d;
            res_count_q <= res_count_d;
            res_id_q    <= res_id_d;
        end
    end

    digit_count_engine #(
        .W  (W),
        .CW (CW)
    ) u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .step_i    (step),
        .operand_i (opnd[grant_idx]),
        .cnt_o     (cnt),
        .last_o    (last)
    );

    assign ack_o       = ack_q;
    assign res_valid_o = valid_q;
    assign res_count_o = res_count_q;
    assign res_id_o    = res_id_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
